mmio_timer_responder: RTL and testbench

// - Memory-mapped timer peripheral; responder on the CPU data-memory port (word address, write enable, write data, read result).
// - Sits beside data_memory in the machine. The top level routes read_result from this block when hit=1, else from data_memory.
// - Provides a prescaled 32-bit counter, compare match, overflow flag and level interrupt.

---
 rtl/mmio_timer_responder.sv | 192 +++++++++++++++++++
 tb/tb_mmio_timer_responder.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder
//   Memory-mapped timer peripheral that answers on the CPU data-memory port.
//   It sits beside data_memory; the top level takes read_result from this
//   block when hit=1, otherwise from data_memory.
//   Provides a prescaled 32-bit counter with compare match, overflow flag and
//   a registered level interrupt.
//
// Ports
//   clock         sole clock, rising edge
//   reset         synchronous, active-high
//   address       [31:2] CPU word address (30 bits)
//   write_enable  store strobe, sampled at the rising edge
//   write_input   store data
//   read_result   load data, combinational, 0 when hit=0
//   hit           address falls inside the 8-word window at BASE_ADDRESS
//   irq           IRQ_EN & (MATCH | OVF), registered
//
// Register map (word offset = address[2:0])
//   0 CTRL      [0] EN  [1] AUTO_RELOAD  [2] IRQ_EN
//   1 PRESCALE  tick every PRESCALE+1 running cycles
//   2 COUNT
//   3 COMPARE
//   4 STATUS    [0] MATCH  [1] OVF, write-1-to-clear
//   5 CYCLE_LO  6 CYCLE_HI (only with MMIO_TIMER_CYCLE_COUNTER_EN, else 0)
//   7 reserved  reads 0, writes ignored
//
// Build option
//   MMIO_TIMER_CYCLE_COUNTER_EN: adds a 64-bit free-running cycle counter at
//   offsets 5/6. Software reads HI, LO, HI to detect a carry between halves.

module mmio_timer_responder #(
  parameter logic [31:0] BASE_ADDRESS   = 32'hFFFF_0000,
  parameter int          PRESCALE_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] address,
  input  logic        write_enable,
  input  logic [31:0] write_input,
  output logic [31:0] read_result,
  output logic        hit,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_CYC_LO   = 3'd5;
  localparam logic [2:0] OFF_CYC_HI   = 3'd6;

  localparam logic [PRESCALE_WIDTH-1:0] PC_ONE = PRESCALE_WIDTH'(1);

  // The timer state is exactly CTRL.EN.
  typedef enum logic {IDLE = 1'b0, RUNNING = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic                      auto_reload_q;
  logic                      irq_en_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] pc_q;
  logic [31:0]               count_q;
  logic [31:0]               compare_q;
  logic                      match_q;
  logic                      ovf_q;
  logic                      irq_q;

  logic [2:0] offset;
  logic       wr;
  logic       wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  logic       tick;
  logic       match_set;
  logic       ovf_set;

  assign hit    = (address[29:3] == BASE_ADDRESS[31:5]);
  assign offset = address[2:0];
  assign wr     = write_enable & hit;

  assign wr_ctrl     = wr & (offset == OFF_CTRL);
  assign wr_prescale = wr & (offset == OFF_PRESCALE);
  assign wr_count    = wr & (offset == OFF_COUNT);
  assign wr_compare  = wr & (offset == OFF_COMPARE);
  assign wr_status   = wr & (offset == OFF_STATUS);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: a CPU write to CTRL always overrides the one-shot expiry,
  // whichever value of EN it writes.
  always_comb begin
    state_d = state_q;
    if (wr_ctrl)
      state_d = write_input[0] ? RUNNING : IDLE;
    else if (match_set && !auto_reload_q)
      state_d = IDLE;
  end

  // Outputs of the state machine: tick and the flag-set events it causes.
  always_comb begin
    tick      = 1'b0;
    match_set = 1'b0;
    ovf_set   = 1'b0;
    if (state_q == RUNNING && pc_q == prescale_q) begin
      tick = 1'b1;
      if (count_q == compare_q)     match_set = 1'b1;
      else if (count_q == '1)       ovf_set   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      auto_reload_q <= 1'b0;
      irq_en_q      <= 1'b0;
      prescale_q    <= '0;
      compare_q     <= 32'hFFFF_FFFF;
    end else begin
      if (wr_ctrl) begin
        auto_reload_q <= write_input[1];
        irq_en_q      <= write_input[2];
      end
      if (wr_prescale) prescale_q <= write_input[PRESCALE_WIDTH-1:0];
      if (wr_compare)  compare_q  <= write_input;
    end
  end

  // Prescale counter restarts whenever CTRL or PRESCALE is written so a new
  // configuration always begins with a full tick period.
  always_ff @(posedge clock) begin
    if (reset)                      pc_q <= '0;
    else if (wr_ctrl || wr_prescale) pc_q <= '0;
    else if (state_q == RUNNING)    pc_q <= tick ? '0 : pc_q + PC_ONE;
  end

  // A CPU write to COUNT wins over the tick update in the same cycle.
  always_ff @(posedge clock) begin
    if (reset)         count_q <= '0;
    else if (wr_count) count_q <= write_input;
    else if (match_set) begin
      if (auto_reload_q) count_q <= '0;
    end else if (tick) count_q <= count_q + 32'd1;
  end

  // Set events win over a write-1-to-clear in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      match_q <= match_set | (match_q & ~(wr_status & write_input[0]));
      ovf_q   <= ovf_set   | (ovf_q   & ~(wr_status & write_input[1]));
      irq_q   <= irq_en_q & (match_q | ovf_q);
    end
  end

  assign irq = irq_q;

`ifdef MMIO_TIMER_CYCLE_COUNTER_EN
  logic [63:0] cycle_q;

  always_ff @(posedge clock) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 64'd1;
  end
`endif

  always_comb begin
    read_result = '0;
    if (hit) begin
      case (offset)
        OFF_CTRL:     read_result = {29'd0, irq_en_q, auto_reload_q, state_q == RUNNING};
        OFF_PRESCALE: read_result = 32'(prescale_q);
        OFF_COUNT:    read_result = count_q;
        OFF_COMPARE:  read_result = compare_q;
        OFF_STATUS:   read_result = {30'd0, ovf_q, match_q};
`ifdef MMIO_TIMER_CYCLE_COUNTER_EN
        OFF_CYC_LO:   read_result = cycle_q[31:0];
        OFF_CYC_HI:   read_result = cycle_q[63:32];
`else
        OFF_CYC_LO:   read_result = '0;
        OFF_CYC_HI:   read_result = '0;
`endif
        default:      read_result = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Testbench for mmio_timer_responder: scenario tasks push expected values to
// a scoreboard queue, then sample the DUT and pop/compare.

`timescale 1ns/1ps

module tb_mmio_timer_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [29:0] OUT_ADDR = 30'h0000_0400; // 32'h0000_1000 >> 2

  logic        clock;
  logic        reset;
  logic [29:0] address;
  logic        write_enable;
  logic [31:0] write_input;
  logic [31:0] read_result;
  logic        hit;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          kind;   // 0 read_result, 1 irq, 2 hit
    logic [29:0] addr;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];

  mmio_timer_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .write_enable (write_enable),
    .write_input  (write_input),
    .read_result  (read_result),
    .hit          (hit),
    .irq          (irq)
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  function automatic logic [29:0] reg_addr(input logic [2:0] off);
    return {BASE[31:5], off};
  endfunction

  function automatic void exp_rd(input string n, input logic [29:0] a, input logic [31:0] v);
    item_t it;
    it.name = n; it.kind = 0; it.addr = a; it.exp = v;
    sb.push_back(it);
  endfunction

  function automatic void exp_irq(input string n, input logic v);
    item_t it;
    it.name = n; it.kind = 1; it.addr = reg_addr(3'd0); it.exp = {31'd0, v};
    sb.push_back(it);
  endfunction

  function automatic void exp_hit(input string n, input logic [29:0] a, input logic v);
    item_t it;
    it.name = n; it.kind = 2; it.addr = a; it.exp = {31'd0, v};
    sb.push_back(it);
  endfunction

  task automatic sample(input item_t it, output logic [31:0] obs);
    address      = it.addr;
    write_enable = 1'b0;
    #1;
    case (it.kind)
      0:       obs = read_result;
      1:       obs = {31'd0, irq};
      default: obs = {31'd0, hit};
    endcase
  endtask

  // Called at a negedge; the write lands on the following posedge and the
  // task returns at the negedge after it.
  task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
    address      = a;
    write_enable = 1'b1;
    write_input  = d;
    @(negedge clock);
    write_enable = 1'b0;
    write_input  = '0;
  endtask

  task automatic test_reset();
    item_t it;
    logic [31:0] obs;
    reset = 1'b1; address = '0; write_enable = 1'b0; write_input = '0;
    @(negedge clock);
    reset = 1'b0;
    exp_rd("rst_ctrl", reg_addr(3'd0), 32'h0);
    exp_rd("rst_prescale", reg_addr(3'd1), 32'h0);
    exp_rd("rst_count", reg_addr(3'd2), 32'h0);
    exp_rd("rst_compare", reg_addr(3'd3), 32'hFFFF_FFFF);
    exp_rd("rst_status", reg_addr(3'd4), 32'h0);
    exp_rd("rst_reserved", reg_addr(3'd7), 32'h0);
    exp_hit("rst_hit_in_window", reg_addr(3'd2), 1'b1);
    exp_irq("rst_irq", 1'b0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_auto_reload_irq();
    item_t it;
    logic [31:0] obs;
    bus_write(reg_addr(3'd1), 32'd3);
    bus_write(reg_addr(3'd3), 32'd5);
    bus_write(reg_addr(3'd0), 32'h7);
    // Now one cycle after the EN edge; ticks land every 4th edge.
    for (int k = 1; k <= 5; k++) begin
      repeat (4) @(negedge clock);
      exp_rd($sformatf("ar_count_step%0d", k), reg_addr(3'd2), 32'(k));
      while (sb.size() != 0) begin
        it = sb.pop_front();
        sample(it, obs);
        checks++;
        if (obs !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
        end
      end
    end
    repeat (3) @(negedge clock);
    exp_rd("ar_status_before_match", reg_addr(3'd4), 32'h0);
    exp_rd("ar_count_before_match", reg_addr(3'd2), 32'd5);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    @(negedge clock);
    exp_rd("ar_status_match", reg_addr(3'd4), 32'h1);
    exp_rd("ar_count_reloaded", reg_addr(3'd2), 32'h0);
    exp_rd("ar_ctrl_still_on", reg_addr(3'd0), 32'h7);
    exp_irq("ar_irq_not_yet", 1'b0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    @(negedge clock);
    exp_irq("ar_irq_set", 1'b1);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    bus_write(reg_addr(3'd4), 32'h1);
    exp_rd("ar_status_cleared", reg_addr(3'd4), 32'h0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    @(negedge clock);
    exp_irq("ar_irq_cleared", 1'b0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
  endtask

  task automatic test_one_shot();
    item_t it;
    logic [31:0] obs;
    bus_write(reg_addr(3'd0), 32'h0);
    bus_write(reg_addr(3'd4), 32'h3);
    bus_write(reg_addr(3'd2), 32'h0);
    bus_write(reg_addr(3'd1), 32'h0);
    bus_write(reg_addr(3'd3), 32'd2);
    bus_write(reg_addr(3'd0), 32'h1);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clock);
      exp_rd($sformatf("os_count%0d", k), reg_addr(3'd2), 32'(k));
      exp_rd($sformatf("os_status%0d", k), reg_addr(3'd4), 32'h0);
      while (sb.size() != 0) begin
        it = sb.pop_front();
        sample(it, obs);
        checks++;
        if (obs !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
        end
      end
    end
    @(negedge clock);
    exp_rd("os_status_match", reg_addr(3'd4), 32'h1);
    exp_rd("os_ctrl_en_cleared", reg_addr(3'd0), 32'h0);
    exp_rd("os_count_held", reg_addr(3'd2), 32'd2);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    repeat (10) @(negedge clock);
    exp_rd("os_count_held_10", reg_addr(3'd2), 32'd2);
    exp_rd("os_ctrl_idle_10", reg_addr(3'd0), 32'h0);
    exp_irq("os_irq_disabled", 1'b0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
  endtask

  task automatic test_overflow();
    item_t it;
    logic [31:0] obs;
    bus_write(reg_addr(3'd0), 32'h0);
    bus_write(reg_addr(3'd4), 32'h3);
    bus_write(reg_addr(3'd2), 32'hFFFF_FFFE);
    bus_write(reg_addr(3'd1), 32'h0);
    bus_write(reg_addr(3'd3), 32'd5);
    bus_write(reg_addr(3'd0), 32'h1);
    @(negedge clock);
    exp_rd("ovf_count_max", reg_addr(3'd2), 32'hFFFF_FFFF);
    exp_rd("ovf_status_none", reg_addr(3'd4), 32'h0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    @(negedge clock);
    exp_rd("ovf_count_wrapped", reg_addr(3'd2), 32'h0);
    exp_rd("ovf_status_ovf", reg_addr(3'd4), 32'h2);
    exp_rd("ovf_ctrl_running", reg_addr(3'd0), 32'h1);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    @(negedge clock);
    exp_irq("ovf_irq_masked", 1'b0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    bus_write(reg_addr(3'd0), 32'h0);
  endtask

  task automatic test_precedence();
    item_t it;
    logic [31:0] obs;
    bus_write(reg_addr(3'd4), 32'h3);
    bus_write(reg_addr(3'd2), 32'h0);
    bus_write(reg_addr(3'd1), 32'h0);
    bus_write(reg_addr(3'd3), 32'd1000);
    bus_write(reg_addr(3'd0), 32'h1);
    // Every edge is a tick now; the COUNT write must win.
    bus_write(reg_addr(3'd2), 32'd100);
    exp_rd("pr_count_write_wins", reg_addr(3'd2), 32'd100);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    bus_write(reg_addr(3'd3), 32'd103);   // count -> 101 on this edge
    repeat (2) @(negedge clock);          // count -> 103
    bus_write(reg_addr(3'd4), 32'h1);     // match sets on this same edge
    exp_rd("pr_match_beats_w1c", reg_addr(3'd4), 32'h1);
    exp_rd("pr_oneshot_ctrl", reg_addr(3'd0), 32'h0);
    exp_rd("pr_count_at_match", reg_addr(3'd2), 32'd103);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    // EN=1 written on the very edge of a one-shot expiry keeps the timer on.
    bus_write(reg_addr(3'd4), 32'h3);
    bus_write(reg_addr(3'd2), 32'd102);
    bus_write(reg_addr(3'd0), 32'h1);     // next edge: count -> 103
    @(negedge clock);
    bus_write(reg_addr(3'd0), 32'h1);     // expiry edge
    exp_rd("pr_en_write_wins", reg_addr(3'd0), 32'h1);
    exp_rd("pr_expiry_match", reg_addr(3'd4), 32'h1);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    bus_write(reg_addr(3'd0), 32'h0);
  endtask

  task automatic test_out_of_window();
    item_t it;
    logic [31:0] obs;
    logic [31:0] lo0;
    bus_write(OUT_ADDR | 30'd0, 32'h7);
    bus_write(OUT_ADDR | 30'd3, 32'h0);
    bus_write(OUT_ADDR | 30'd2, 32'h55);
    bus_write(reg_addr(3'd7), 32'hDEAD_BEEF);
    exp_hit("oow_hit", OUT_ADDR, 1'b0);
    exp_rd("oow_read_zero", OUT_ADDR | 30'd2, 32'h0);
    exp_rd("oow_ctrl_unchanged", reg_addr(3'd0), 32'h0);
    exp_rd("oow_compare_unchanged", reg_addr(3'd3), 32'd103);
    exp_rd("oow_count_unchanged", reg_addr(3'd2), 32'd103);
    exp_rd("reserved_ignores_write", reg_addr(3'd7), 32'h0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    @(negedge clock);
`ifdef MMIO_TIMER_CYCLE_COUNTER_EN
    address = reg_addr(3'd5);
    #1;
    lo0 = read_result;
    @(negedge clock);
    repeat (9) @(negedge clock);
    exp_rd("cyc_lo_plus10", reg_addr(3'd5), lo0 + 32'd10);
`else
    lo0 = '0;
    exp_rd("cyc_lo_absent", reg_addr(3'd5), lo0);
    exp_rd("cyc_hi_absent", reg_addr(3'd6), lo0);
`endif
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_count();
    item_t it;
    logic [31:0] obs;
    bus_write(reg_addr(3'd4), 32'h3);
    bus_write(reg_addr(3'd2), 32'h0);
    bus_write(reg_addr(3'd1), 32'h0);
    bus_write(reg_addr(3'd3), 32'd1000);
    bus_write(reg_addr(3'd0), 32'h7);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_rd("mid_rst_ctrl", reg_addr(3'd0), 32'h0);
    exp_rd("mid_rst_prescale", reg_addr(3'd1), 32'h0);
    exp_rd("mid_rst_count", reg_addr(3'd2), 32'h0);
    exp_rd("mid_rst_compare", reg_addr(3'd3), 32'hFFFF_FFFF);
    exp_rd("mid_rst_status", reg_addr(3'd4), 32'h0);
    exp_irq("mid_rst_irq", 1'b0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
    repeat (3) @(negedge clock);
    exp_rd("mid_rst_count_idle", reg_addr(3'd2), 32'h0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      sample(it, obs);
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", it.name, obs, it.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_auto_reload_irq();
    @(negedge clock);
    test_one_shot();
    test_overflow();
    test_precedence();
    test_out_of_window();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
